seq_div_nr32: RTL and testbench

- Multi-cycle unsigned integer divider. It is the inverse-direction companion to the team's 32-bit carry-select add/subtract datapath.
- Uses the non-restoring algorithm. Each cycle runs one shared (WIDTH+1)-bit add/subtract step with the same convention as the adder: B operand XORed with the sub control, and the sub control used as carry-in.
- Sits beside the add/sub unit in the arithmetic block. It is started by a one-cycle pulse and reports its result with a one-cycle done pulse.

---
 rtl/seq_div_nr32.sv | 112 +++++++++++
 tb/tb_seq_div_nr32.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_nr32.sv
// Multi-cycle unsigned non-restoring divider: one shared (WIDTH+1)-bit add/sub step per cycle,
// started by a one-cycle pulse, result flagged by a one-cycle done pulse.
module seq_div_nr32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH:0]   r_p;
  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;

  logic             w_sub;
  logic [WIDTH:0]   w_add_a;
  logic [WIDTH:0]   w_add_b;
  logic [WIDTH:0]   w_sum;
  logic             w_last;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Shared adder: RUN feeds the shifted partial remainder, FIX feeds P unshifted with sub=0.
  always_comb begin
    w_sub   = 1'b0;
    w_add_a = r_p;
    if (r_state == S_RUN) begin
      w_sub   = ~r_p[WIDTH];
      w_add_a = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    end
  end

  assign w_add_b = r_d ^ {(WIDTH+1){w_sub}};
  assign w_sum   = w_add_a + w_add_b + {{WIDTH{1'b0}}, w_sub};

  assign busy = (r_state == S_RUN) || (r_state == S_FIX);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_next = (divisor == '0) ? S_DONE : S_RUN;
        else       w_state_next = S_IDLE;
      end
      S_RUN:   if (w_last) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p         <= '0;
      r_d         <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (divisor != '0) begin
              r_d   <= {1'b0, divisor};
              r_p   <= '0;
              r_q   <= dividend;
              r_cnt <= '0;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_p   <= w_sum;
          r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          // A negative final partial remainder gets one restoring add.
          if (r_p[WIDTH]) r_p <= w_sum;
          quotient    <= r_q;
          remainder   <= r_p[WIDTH] ? w_sum[WIDTH-1:0] : r_p[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_nr32.sv
// Scoreboard bench for seq_div_nr32: stimulus pushes expected results, a negedge monitor checks each done.
module tb_seq_div_nr32;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  seq_div_nr32 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   n_push = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, with the all-ones/dividend convention for a zero divisor.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.a   = a;
    e.b   = b;
    e.dbz = (b == '0);
    e.q   = e.dbz ? '1 : a / b;
    e.r   = e.dbz ? a : a % b;
    e.cyc = cyc + (e.dbz ? 1 : W + 2);
    sb.push_back(e);
    n_push++;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    drive_start(a, b);
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();
  endtask

  exp_t m;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        m = sb.pop_front();
        $display("[TB] %0h / %0h -> q=%0h r=%0h dbz=%0b at cycle %0d", m.a, m.b, quotient, remainder, div_by_zero, cyc);
        chk("quotient", 64'(quotient), 64'(m.q));
        chk("remainder", 64'(remainder), 64'(m.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(m.dbz));
        chk("done_cycle", 64'(cyc), 64'(m.cyc));
        if (!m.dbz)
          chk("invariant",
              64'((64'(quotient) * 64'(m.b) + 64'(remainder) == 64'(m.a)) && (remainder < m.b)),
              64'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [W-1:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;

    // Basic division with busy window check: busy in cycles 1..33, done in 34.
    drive_start(32'd100, 32'd7);
    bad = 0;
    for (int k = 1; k <= W + 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (busy !== (k <= W + 1)) bad++;
    end
    chk("busy_window", 64'(bad), 64'd0);
    wait_drain();

    do_op(32'hFFFF_FFFF, 32'd1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(32'h8000_0000, 32'd3);
    do_op(32'd0, 32'd9);

    // Divide by zero: done next cycle, busy never rises.
    drive_start(32'd5, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("dbz_busy_c1", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("dbz_busy_c2", 64'(busy), 64'd0);
    wait_drain();

    // Dividend < divisor, then back-to-back start held in the DONE cycle.
    drive_start(32'd3, 32'd10);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W + 1) @(posedge clk);
    #1;
    chk("done_for_b2b", 64'(done), 64'd1);
    drive_start(32'd1000, 32'd33);
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();

    // Start during RUN is ignored.
    drive_start(32'd100, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'd9; divisor = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();
    repeat (40) @(posedge clk);
    #1;
    chk("done_count_busy_start", 64'(n_done), 64'(n_push));

    // Reset in RUN cycle 15 aborts without a done pulse.
    drive_start(32'd100, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    n_push--;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_remainder", 64'(remainder), 64'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("done_count_abort", 64'(n_done), 64'(n_push));
    do_op(32'd77, 32'd7);

    // Randomised back-to-back operations with varied operand magnitudes.
    for (int i = 0; i < 1500; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == '0) rb = 32'd1;
      drive_start(ra, rb);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (W + 1) @(posedge clk);
      #1;
    end
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    chk("done_count_final", 64'(n_done), 64'(n_push));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
